sdram_resp: RTL and testbench

- Cycle-accurate SDRAM device-side responder; the other end of the controller command bus.
- Decodes {cke,cs_n,ras_n,cas_n,we_n}, ba and addr, and tracks the mode register and per-bank open rows.
- Stores write bursts and returns read bursts after the programmed CAS latency; flags protocol violations.
- Sits in the controller's simulation/loopback top in place of the external SDRAM chip.

---
 rtl/sdram_resp_pkg.sv | 40 ++++
 rtl/sdram_resp_mem.sv | 22 ++
 rtl/sdram_resp.sv | 227 ++++++++++++++++++++++
 tb/tb_sdram_resp.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_resp_pkg.sv
// Shared definitions for the SDRAM device-side responder: command encodings,
// error cause codes and the mode-register burst-length decode.
package sdram_resp_pkg;

  typedef enum logic [2:0] {
    CMD_LMR   = 3'b000,
    CMD_AREF  = 3'b001,
    CMD_PRE   = 3'b010,
    CMD_ACT   = 3'b011,
    CMD_WRITE = 3'b100,
    CMD_READ  = 3'b101,
    CMD_BSTOP = 3'b110,
    CMD_NOP   = 3'b111
  } cmd_t;

  localparam logic [2:0] ERR_NO_MODE     = 3'd1;
  localparam logic [2:0] ERR_REOPEN      = 3'd2;
  localparam logic [2:0] ERR_BANK_CLOSED = 3'd3;
  localparam logic [2:0] ERR_BAD_MODE    = 3'd4;
  localparam logic [2:0] ERR_LMR_OPEN    = 3'd5;
  localparam logic [2:0] ERR_AREF_OPEN   = 3'd6;

  localparam logic [2:0] CL_DEFAULT = 3'd3;
  localparam logic [8:0] BL_PAGE    = 9'd256;

  // Returns the burst length in words, or 0 for a reserved encoding.
  function automatic logic [8:0] bl_decode(input logic [2:0] code);
    logic [8:0] len;
    case (code)
      3'b000:  len = 9'd1;
      3'b001:  len = 9'd2;
      3'b010:  len = 9'd4;
      3'b011:  len = 9'd8;
      3'b111:  len = BL_PAGE;
      default: len = 9'd0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/sdram_resp_mem.sv
// Synchronous storage array for the responder. The write port serves write
// bursts while the registered read port feeds the read pipeline in the same cycle.
module sdram_resp_mem #(
  parameter int DW = 16,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/sdram_resp.sv
// Cycle-accurate SDRAM chip model: decodes the command bus, tracks mode and
// open rows, stores write bursts and returns read bursts after CAS latency.
module sdram_resp
  import sdram_resp_pkg::*;
#(
  parameter int DW       = 16,
  parameter int ROW_USED = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sdram_cke,
  input  logic          sdram_cs_n,
  input  logic          sdram_ras_n,
  input  logic          sdram_cas_n,
  input  logic          sdram_we_n,
  input  logic [1:0]    sdram_ba,
  input  logic [11:0]   sdram_addr,
  input  logic [DW-1:0] dq_in,
  output logic [DW-1:0] dq_out,
  output logic          dq_oe,
  output logic          err,
  output logic [2:0]    err_code,
  output logic [15:0]   ref_cnt
);

  localparam int AW = ROW_USED + 10;

  cmd_t          cmd;
  logic [3:0]    bank_open;
  logic [11:0]   open_row [4];
  logic          mode_valid;
  logic [2:0]    cl;
  logic [8:0]    bl;
  logic [2:0]    cl_new;
  logic [8:0]    bl_new;
  logic          pre_all;
  logic [AW-1:0] cmd_addr;
  logic          rw_ok;
  logic          err_now;
  logic [2:0]    err_now_code;
  logic          rd_active, wr_active;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [8:0]    rd_left, wr_left;
  logic          rd_start, wr_start, rd_stop, wr_stop;
  logic          rd_issue;
  logic [AW-1:0] rd_issue_addr;
  logic          mem_we;
  logic [AW-1:0] mem_waddr, mem_raddr;
  logic [DW-1:0] mem_rdata;
  logic [2:0]    pipe_v;
  logic [AW-1:0] pipe_a [2];
  logic          out_v;
  logic          unused_row;

  // Column increment wraps inside the row; bank and row bits are untouched.
  function automatic logic [AW-1:0] next_col(input logic [AW-1:0] a);
    return {a[AW-1:8], a[7:0] + 8'd1};
  endfunction

  assign cl_new     = sdram_addr[6:4];
  assign bl_new     = bl_decode(sdram_addr[2:0]);
  assign pre_all    = sdram_addr[10];
  assign cmd_addr   = {sdram_ba, open_row[sdram_ba][ROW_USED-1:0], sdram_addr[7:0]};
  assign unused_row = ^{open_row[0][11:ROW_USED], open_row[1][11:ROW_USED],
                        open_row[2][11:ROW_USED], open_row[3][11:ROW_USED]};

  always_comb begin
    cmd = CMD_NOP;
    if (sdram_cke && !sdram_cs_n)
      cmd = cmd_t'({sdram_ras_n, sdram_cas_n, sdram_we_n});
  end

  always_comb begin
    rw_ok        = 1'b0;
    err_now      = 1'b0;
    err_now_code = '0;
    case (cmd)
      CMD_READ, CMD_WRITE: begin
        if (!mode_valid) begin
          err_now      = 1'b1;
          err_now_code = ERR_NO_MODE;
        end else if (!bank_open[sdram_ba]) begin
          err_now      = 1'b1;
          err_now_code = ERR_BANK_CLOSED;
        end else begin
          rw_ok = 1'b1;
        end
      end
      CMD_ACT: begin
        if (bank_open[sdram_ba]) begin
          err_now      = 1'b1;
          err_now_code = ERR_REOPEN;
        end
      end
      CMD_LMR: begin
        if (|bank_open) begin
          err_now      = 1'b1;
          err_now_code = ERR_LMR_OPEN;
        end else if ((cl_new != 3'd2 && cl_new != 3'd3) || bl_new == 9'd0) begin
          err_now      = 1'b1;
          err_now_code = ERR_BAD_MODE;
        end
      end
      CMD_AREF: begin
        if (|bank_open) begin
          err_now      = 1'b1;
          err_now_code = ERR_AREF_OPEN;
        end
      end
      default: ;
    endcase
  end

  // A new burst command owns the data bus, so it cuts off whichever burst is running.
  always_comb begin
    rd_start      = (cmd == CMD_READ) && rw_ok;
    wr_start      = (cmd == CMD_WRITE) && rw_ok;
    rd_stop       = (cmd inside {CMD_READ, CMD_WRITE, CMD_BSTOP}) ||
                    (cmd == CMD_PRE && (pre_all || sdram_ba == rd_addr[AW-1 -: 2]));
    wr_stop       = (cmd inside {CMD_READ, CMD_WRITE, CMD_BSTOP}) ||
                    (cmd == CMD_PRE && (pre_all || sdram_ba == wr_addr[AW-1 -: 2]));
    rd_issue      = rd_start || (rd_active && sdram_cke && !rd_stop);
    rd_issue_addr = rd_start ? cmd_addr : rd_addr;
    mem_we        = wr_start || (wr_active && sdram_cke && !wr_stop);
    mem_waddr     = wr_start ? cmd_addr : wr_addr;
  end

  assign mem_raddr = (cl == 3'd2) ? pipe_a[0] : pipe_a[1];
  assign out_v     = (cl == 3'd2) ? pipe_v[1] : pipe_v[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_open  <= '0;
      for (int i = 0; i < 4; i++) open_row[i] <= '0;
      mode_valid <= 1'b0;
      cl         <= CL_DEFAULT;
      bl         <= BL_PAGE;
      ref_cnt    <= '0;
      err        <= 1'b0;
      err_code   <= '0;
    end else begin
      err <= err_now;
      if (err_now) err_code <= err_now_code;
      case (cmd)
        CMD_ACT: begin
          bank_open[sdram_ba] <= 1'b1;
          open_row[sdram_ba]  <= sdram_addr;
        end
        CMD_PRE: begin
          if (pre_all) bank_open <= '0;
          else         bank_open[sdram_ba] <= 1'b0;
        end
        CMD_AREF: begin
          if (ref_cnt != 16'hFFFF) ref_cnt <= ref_cnt + 16'd1;
        end
        CMD_LMR: begin
          if (bank_open == '0) begin
            if (cl_new == 3'd2 || cl_new == 3'd3) cl <= cl_new;
            if (bl_new != 9'd0) bl <= bl_new;
            mode_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // The pipeline keeps shifting on cke=0 cycles; only the burst generators pause.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_active <= 1'b0;
      rd_addr   <= '0;
      rd_left   <= '0;
      wr_active <= 1'b0;
      wr_addr   <= '0;
      wr_left   <= '0;
      pipe_v    <= '0;
      pipe_a[0] <= '0;
      pipe_a[1] <= '0;
      dq_oe     <= 1'b0;
      dq_out    <= '0;
    end else begin
      if (rd_start) begin
        rd_active <= (bl != 9'd1);
        rd_addr   <= next_col(cmd_addr);
        rd_left   <= bl - 9'd1;
      end else if (rd_stop) begin
        rd_active <= 1'b0;
      end else if (rd_issue) begin
        rd_active <= (rd_left > 9'd1);
        rd_addr   <= next_col(rd_addr);
        rd_left   <= rd_left - 9'd1;
      end

      if (wr_start) begin
        wr_active <= (bl != 9'd1);
        wr_addr   <= next_col(cmd_addr);
        wr_left   <= bl - 9'd1;
      end else if (wr_stop) begin
        wr_active <= 1'b0;
      end else if (mem_we) begin
        wr_active <= (wr_left > 9'd1);
        wr_addr   <= next_col(wr_addr);
        wr_left   <= wr_left - 9'd1;
      end

      pipe_v    <= {pipe_v[1:0], rd_issue};
      pipe_a[0] <= rd_issue_addr;
      pipe_a[1] <= pipe_a[0];
      dq_oe     <= out_v;
      if (out_v) dq_out <= mem_rdata;
    end
  end

  sdram_resp_mem #(
    .DW(DW),
    .AW(AW)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .waddr(mem_waddr),
    .wdata(dq_in),
    .raddr(mem_raddr),
    .rdata(mem_rdata)
  );

endmodule

// File: tb/tb_sdram_resp.sv
// Bench for sdram_resp: a table of single commands with expected status, plus
// burst sequences whose read words are scored against a local memory model.
module tb_sdram_resp;

  localparam logic [2:0] C_LMR  = 3'b000;
  localparam logic [2:0] C_AREF = 3'b001;
  localparam logic [2:0] C_PRE  = 3'b010;
  localparam logic [2:0] C_ACT  = 3'b011;
  localparam logic [2:0] C_WR   = 3'b100;
  localparam logic [2:0] C_RD   = 3'b101;
  localparam logic [2:0] C_BST  = 3'b110;
  localparam logic [2:0] C_NOP  = 3'b111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cke, cs_n, ras_n, cas_n, we_n;
  logic [1:0]  ba;
  logic [11:0] addr;
  logic [15:0] dq_in, dq_out;
  logic        dq_oe, err;
  logic [2:0]  err_code;
  logic [15:0] ref_cnt;

  typedef struct {
    logic [2:0]  cmd;
    logic [1:0]  ba;
    logic [11:0] addr;
    logic        err;
    logic [2:0]  code;
    logic [15:0] refs;
    string       name;
  } vec_t;

  typedef struct {
    int          due;
    logic [15:0] data;
  } exp_t;

  vec_t        vecs [20];
  exp_t        exp_q [$];
  exp_t        mon_e;
  logic [15:0] model [int];
  int          checks = 0;
  int          errors = 0;
  int          edge_cnt = 0;
  int          cl = 3;
  logic        mon_en = 1'b0;

  sdram_resp #(
    .DW(16),
    .ROW_USED(2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sdram_cke  (cke),
    .sdram_cs_n (cs_n),
    .sdram_ras_n(ras_n),
    .sdram_cas_n(cas_n),
    .sdram_we_n (we_n),
    .sdram_ba   (ba),
    .sdram_addr (addr),
    .dq_in      (dq_in),
    .dq_out     (dq_out),
    .dq_oe      (dq_oe),
    .err        (err),
    .err_code   (err_code),
    .ref_cnt    (ref_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Every driven read word must appear exactly at its due edge; stray words fail too.
  always @(negedge clk) begin
    if (mon_en) begin
      if (dq_oe === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL dq_unexpected edge %0d got %h expected no word", edge_cnt, dq_out);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.due != edge_cnt || dq_out !== mon_e.data) begin
            errors++;
            $display("[TB] FAIL dq_word edge %0d got %h expected %h at edge %0d",
                     edge_cnt, dq_out, mon_e.data, mon_e.due);
          end
        end
      end else if (exp_q.size() != 0 && exp_q[0].due <= edge_cnt) begin
        checks++;
        errors++;
        mon_e = exp_q.pop_front();
        $display("[TB] FAIL dq_missing edge %0d got oe=%b expected %h", edge_cnt, dq_oe, mon_e.data);
      end
    end
  end

  function automatic int memKey(input logic [1:0] b, input logic [11:0] row, input logic [7:0] col);
    return int'({b, row[1:0], col});
  endfunction

  task automatic setVec(input int i, input logic [2:0] c, input logic [1:0] b, input logic [11:0] a,
                        input logic e, input logic [2:0] code, input logic [15:0] refs, input string name);
    vecs[i].cmd  = c;
    vecs[i].ba   = b;
    vecs[i].addr = a;
    vecs[i].err  = e;
    vecs[i].code = code;
    vecs[i].refs = refs;
    vecs[i].name = name;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] c, input logic [1:0] b, input logic [11:0] a, input logic [15:0] d);
    cke   = 1'b1;
    cs_n  = 1'b0;
    {ras_n, cas_n, we_n} = c;
    ba    = b;
    addr  = a;
    dq_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(C_NOP, 2'd0, 12'h000, 16'h0000);
  endtask

  task automatic runVectors(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      applyStimulus(vecs[i].cmd, vecs[i].ba, vecs[i].addr, 16'h0000);
      checkOutput({vecs[i].name, "_err"}, {15'b0, err}, {15'b0, vecs[i].err});
      checkOutput({vecs[i].name, "_code"}, {13'b0, err_code}, {13'b0, vecs[i].code});
      checkOutput({vecs[i].name, "_ref"}, ref_cnt, vecs[i].refs);
    end
  endtask

  // Streams n words from dq_in then stops the burst with BSTOP.
  task automatic writeBurst(input logic [1:0] b, input logic [11:0] row, input logic [7:0] col,
                            input int n, input logic [15:0] base);
    logic [7:0] c;
    for (int i = 0; i < n; i++) begin
      c = col + 8'(i);
      model[memKey(b, row, c)] = base + 16'(i);
      applyStimulus((i == 0) ? C_WR : C_NOP, b, {4'h0, col}, base + 16'(i));
    end
    applyStimulus(C_BST, b, 12'h000, 16'h0000);
  endtask

  // Issues READ, expects n words from the model, and returns after n command slots.
  task automatic readBurst(input logic [1:0] b, input logic [11:0] row, input logic [7:0] col, input int n);
    int         k;
    logic [7:0] c;
    exp_t       e;
    applyStimulus(C_RD, b, {4'h0, col}, 16'h0000);
    k = edge_cnt;
    for (int i = 0; i < n; i++) begin
      c      = col + 8'(i);
      e.due  = k + cl + i;
      e.data = model[memKey(b, row, c)];
      exp_q.push_back(e);
    end
    repeat (n - 1) applyStimulus(C_NOP, b, 12'h000, 16'h0000);
  endtask

  initial begin
    cke = 1'b0; cs_n = 1'b1; ras_n = 1'b1; cas_n = 1'b1; we_n = 1'b1;
    ba = 2'd0; addr = 12'h000; dq_in = 16'h0000;

    setVec(0,  C_PRE,  2'd0, 12'hFFF, 1'b0, 3'd0, 16'd0, "init_pre_all");
    setVec(1,  C_AREF, 2'd0, 12'h000, 1'b0, 3'd0, 16'd1, "init_aref1");
    setVec(2,  C_AREF, 2'd0, 12'h000, 1'b0, 3'd0, 16'd2, "init_aref2");
    setVec(3,  C_LMR,  2'd0, 12'h037, 1'b0, 3'd0, 16'd2, "init_lmr");
    setVec(4,  C_ACT,  2'd1, 12'h005, 1'b0, 3'd0, 16'd2, "act_b1");
    setVec(5,  C_PRE,  2'd0, 12'h400, 1'b0, 3'd0, 16'd2, "pre_all");
    setVec(6,  C_LMR,  2'd0, 12'h023, 1'b0, 3'd0, 16'd2, "lmr_cl2_bl8");
    setVec(7,  C_ACT,  2'd1, 12'h005, 1'b0, 3'd0, 16'd2, "act_b1_again");
    setVec(8,  C_RD,   2'd2, 12'h000, 1'b1, 3'd3, 16'd2, "rd_closed_bank");
    setVec(9,  C_ACT,  2'd0, 12'h001, 1'b0, 3'd3, 16'd2, "act_b0");
    setVec(10, C_ACT,  2'd0, 12'h002, 1'b1, 3'd2, 16'd2, "act_b0_twice");
    setVec(11, C_NOP,  2'd0, 12'h000, 1'b0, 3'd2, 16'd2, "code_held");
    setVec(12, C_LMR,  2'd0, 12'h023, 1'b1, 3'd5, 16'd2, "lmr_while_open");
    setVec(13, C_AREF, 2'd0, 12'h000, 1'b1, 3'd6, 16'd3, "aref_while_open");
    setVec(14, C_PRE,  2'd0, 12'h400, 1'b0, 3'd6, 16'd3, "pre_all2");
    setVec(15, C_LMR,  2'd0, 12'h053, 1'b1, 3'd4, 16'd3, "lmr_bad_cl");
    setVec(16, C_ACT,  2'd1, 12'h005, 1'b0, 3'd4, 16'd3, "act_b1_third");
    setVec(17, C_RD,   2'd1, 12'h000, 1'b1, 3'd1, 16'd0, "rd_no_mode");
    setVec(18, C_LMR,  2'd0, 12'h037, 1'b0, 3'd1, 16'd0, "lmr_after_reset");
    setVec(19, C_RD,   2'd1, 12'h000, 1'b1, 3'd3, 16'd0, "rd_bank_closed_after_reset");

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_dq_oe", {15'b0, dq_oe}, 16'h0000);
    checkOutput("reset_err", {15'b0, err}, 16'h0000);
    checkOutput("reset_err_code", {13'b0, err_code}, 16'h0000);
    checkOutput("reset_ref_cnt", ref_cnt, 16'h0000);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    runVectors(0, 4);
    writeBurst(2'd1, 12'h005, 8'h00, 8, 16'h1111);
    idle(1);
    readBurst(2'd1, 12'h005, 8'h00, 8);
    applyStimulus(C_BST, 2'd1, 12'h000, 16'h0000);
    idle(6);
    writeBurst(2'd1, 12'h005, 8'hFE, 4, 16'hA001);
    idle(1);
    readBurst(2'd1, 12'h005, 8'hFE, 4);
    applyStimulus(C_BST, 2'd1, 12'h000, 16'h0000);
    idle(6);

    runVectors(5, 7);
    cl = 2;
    readBurst(2'd1, 12'h005, 8'h00, 8);
    idle(6);
    readBurst(2'd1, 12'h005, 8'h02, 2);
    readBurst(2'd1, 12'h005, 8'hFE, 8);
    idle(6);

    runVectors(8, 16);
    readBurst(2'd1, 12'h005, 8'h00, 3);
    #6;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    checkOutput("mid_reset_dq_oe", {15'b0, dq_oe}, 16'h0000);
    checkOutput("mid_reset_dq_out", dq_out, 16'h0000);
    checkOutput("mid_reset_err_code", {13'b0, err_code}, 16'h0000);
    cl = 3;
    @(negedge clk);
    rst_n = 1'b1;

    runVectors(17, 19);
    idle(4);
    checkOutput("scoreboard_empty", 16'(exp_q.size()), 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
